csi2_deskew_cal: RTL and testbench
==================================

# csi2_deskew_cal

Automatic per-lane D-PHY input-delay calibrator for the CSI-2 receiver. It sweeps each data lane's IDELAY tap over its full range while holding the other lanes fixed, and scores every tap by CSI-2 header and CRC errors over whole frames. It then programs each lane to the centre of its widest error-free window. It sits in the pixel-clock domain between the CSR block and the receiver's `lane_delay_i` / `delay_act_i`. The wrapper muxes CSR delays against this block's outputs under a CSR select bit.

## Interface
- DATA_LANES, 2, number of D-PHY data lanes
- DELAY_WIDTH, 5, tap width; taps 0..2^DELAY_WIDTH-1
- SETTLE_FRAMES, 1, frame starts skipped after each tap change
- MEAS_FRAMES, 2, frame starts spanned by one measurement
- ERR_THRESH, 0, maximum accumulated errors for a tap to count as good
- TIMEOUT_CYCLES, 2^24, maximum cycles between frame starts before the tap is declared bad

Ports:
- clk_i  in  1  pixel clock; the only clock
- srst_i  in  1  reset, synchronous, active-high
- start_i  in  1  calibration request pulse
- init_delay_i  in  [DATA_LANES-1:0][DELAY_WIDTH-1:0]  base taps; also the fallback value for a failed lane
- frame_start_i  in  1  one-cycle pulse, tvalid & tready & tuser of the video stream
- header_err_i  in  1  uncorrectable header error pulse
- crc_err_i  in  1  payload CRC error pulse
- lane_delay_o  out  [DATA_LANES-1:0][DELAY_WIDTH-1:0]  tap values driven to the receiver
- delay_act_o  out  1  load strobe for the receiver's delay lines
- busy_o  out  1  calibration in progress
- done_o  out  1  one-cycle completion pulse
- lane_fail_o  out  [DATA_LANES-1:0]  lane had no good tap
- eye_width_o  out  [DATA_LANES-1:0][DELAY_WIDTH:0]  length of the best good-tap run per lane

## Operation
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - All counters and trackers 0.
- FSM states: IDLE, LOAD, APPLY, SETTLE, MEASURE, EVAL, COMMIT, DONE.
- IDLE
  - start_i = 1 moves to LOAD.
  - start_i in any other state is ignored.
- LOAD
  - lane_delay_o <= init_delay_i.
  - lane index <= 0, tap <= 0.
  - Run trackers cleared.
- APPLY
  - lane_delay_o[lane] <= tap and delay_act_o <= 1, both in the same cycle.
  - Frame and timeout counters cleared.
  - Next state SETTLE.
- SETTLE
  - Counts SETTLE_FRAMES frame starts; errors are ignored.
  - The error counter is cleared on exit.
  - Next state MEASURE.
- MEASURE
  - Accumulates header_err_i + crc_err_i into an 8-bit saturating counter.
  - Both errors in one cycle add 2.
  - Exits to EVAL on the MEAS_FRAMES-th frame start. Errors in that same cycle are counted.
- Timeout (SETTLE or MEASURE)
  - The cycle counter clears on every frame start.
  - Reaching TIMEOUT_CYCLES-1 marks the tap bad and goes directly to EVAL.
- EVAL
  - good = !timeout && err_cnt <= ERR_THRESH.
  - Good tap: if cur_len = 0, set cur_start <= tap; then cur_len++. If the new cur_len > best_len (strictly greater), copy it to best.
  - Bad tap: cur_len <= 0.
  - If tap = max, go to COMMIT; otherwise tap++ and go to APPLY.
- COMMIT
  - best_len = 0: lane_delay_o[lane] <= init_delay_i[lane] and lane_fail_o[lane] <= 1.
  - Otherwise: lane_delay_o[lane] <= best_start + ((best_len-1) >> 1).
  - eye_width_o[lane] <= best_len.
  - delay_act_o <= 1.
  - Next lane: trackers cleared, tap 0, go to APPLY. After the last lane, go to DONE.
- DONE
  - done_o = 1 for one cycle, then IDLE.
  - lane_delay_o, lane_fail_o and eye_width_o hold until the next LOAD. LOAD clears lane_fail_o and eye_width_o.
- Centre arithmetic is done in DELAY_WIDTH+1 bits and cannot overflow. Ties resolve to the lowest-tap run.
- srst_i mid-sweep: immediate return to reset values; lane_delay_o goes to 0.

## Timing
- start_i sampled high at edge N:
  - busy_o = 1 from N+1.
  - First delay_act_o pulse at N+2, with lane_delay_o = {init[1], 0}.
- delay_act_o is always exactly one cycle long and coincides with the new lane_delay_o value.
- Per tap, with no timeout: 1 (APPLY) + SETTLE + MEASURE frame time + 1 (EVAL).
- Full run: DATA_LANES × 2^DELAY_WIDTH taps, plus one COMMIT cycle per lane.
- busy_o is 0 in the DONE cycle and coincides with done_o.
- frame_start_i, error pulses and the timeout in the same cycle: the frame start takes priority over the timeout.

## Structure
- Package `csi2_deskew_pkg` holds:
  - the state enum;
  - the default DELAY_WIDTH;
  - `ERR_CNT_WIDTH = 8`.
- Sub-module `csi2_eye_tracker` holds the run tracker. It contains cur_start, cur_len, best_start and best_len, has clear, step and good inputs, and outputs best_start and best_len. It is instantiated once and cleared per lane.

## Test plan
- Lane 0 good on taps 10..20, lane 1 good on taps 5..9 and 22..30 -> lane_delay_o = {26, 15}, eye_width_o = {9, 11}, lane_fail_o = 0.
- Lane 1 bad on every tap, init_delay_i[1] = 7 -> lane 1 final tap 7, lane_fail_o = 2'b10, eye_width_o[1] = 0.
- Lane 0 has two equal runs, 2..5 and 20..23 -> lane 0 tap 3, eye_width_o[0] = 4.
- No frame_start_i at all, with TIMEOUT_CYCLES = 64 -> every tap times out, lane_fail_o = 2'b11, done_o within 2 × 32 × 66 cycles plus overhead.
- Errors injected only during SETTLE on taps 0..31 -> all taps good, centre tap 15, eye_width_o = 32.
- start_i pulsed mid-sweep is ignored. srst_i at tap 12 of lane 0 -> all outputs 0 the next cycle, and a later start_i runs a full sweep.

Source files
------------

// File: rtl/csi2_deskew_pkg.sv
// Shared types and constants for the D-PHY per-lane deskew calibrator.
// Holds the sweep FSM encoding, the default tap width and the error counter width.
package csi2_deskew_pkg;

  localparam int DELAY_WIDTH_DEF = 5;
  localparam int ERR_CNT_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    SETTLE,
    MEASURE,
    EVAL,
    COMMIT,
    DONE
  } cal_state_t;

endpackage

// File: rtl/csi2_deskew_cal_if.sv
// Calibrator bus: CSR/receiver-side inputs and the delay-line programming outputs.
// The requester (CSR block / stream monitor) is master; the calibrator is slave.
interface csi2_deskew_cal_if #(
  parameter int DATA_LANES  = 2,
  parameter int DELAY_WIDTH = csi2_deskew_pkg::DELAY_WIDTH_DEF
);
  logic                                   start_i;
  logic [DATA_LANES-1:0][DELAY_WIDTH-1:0] init_delay_i;
  logic                                   frame_start_i;
  logic                                   header_err_i;
  logic                                   crc_err_i;
  logic [DATA_LANES-1:0][DELAY_WIDTH-1:0] lane_delay_o;
  logic                                   delay_act_o;
  logic                                   busy_o;
  logic                                   done_o;
  logic [DATA_LANES-1:0]                  lane_fail_o;
  logic [DATA_LANES-1:0][DELAY_WIDTH:0]   eye_width_o;

  modport master (
    output start_i, init_delay_i, frame_start_i, header_err_i, crc_err_i,
    input  lane_delay_o, delay_act_o, busy_o, done_o, lane_fail_o, eye_width_o
  );

  modport slave (
    input  start_i, init_delay_i, frame_start_i, header_err_i, crc_err_i,
    output lane_delay_o, delay_act_o, busy_o, done_o, lane_fail_o, eye_width_o
  );
endinterface

// File: rtl/csi2_eye_tracker.sv
// Tracks the current and the longest run of good taps within one lane's sweep.
// Updates one cycle after step; no backpressure, a strictly longer run replaces best.
module csi2_eye_tracker #(
  parameter int DELAY_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   clear,
  input  logic                   step,
  input  logic                   good,
  input  logic [DELAY_WIDTH-1:0] tap,
  output logic [DELAY_WIDTH-1:0] best_start,
  output logic [DELAY_WIDTH:0]   best_len
);

  logic [DELAY_WIDTH-1:0] cur_start;
  logic [DELAY_WIDTH:0]   cur_len;
  logic [DELAY_WIDTH-1:0] run_start;
  logic [DELAY_WIDTH:0]   run_len;

  assign run_start = (cur_len == '0) ? tap : cur_start;
  assign run_len   = cur_len + (DELAY_WIDTH+1)'(1);

  always_ff @(posedge clk_i) begin
    if (srst_i || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (step) begin
      if (good) begin
        cur_start <= run_start;
        cur_len   <= run_len;
        // Equal-length later runs never replace best, so ties keep the lowest tap.
        if (run_len > best_len) begin
          best_start <= run_start;
          best_len   <= run_len;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

endmodule

// File: rtl/csi2_deskew_cal.sv
// Per-lane IDELAY sweep: scores each tap on header/CRC errors over whole frames, programs eye centres.
// Outputs registered, first delay_act two cycles after start; frame pacing sets sweep rate, no backpressure.
module csi2_deskew_cal
  import csi2_deskew_pkg::*;
#(
  parameter int DATA_LANES     = 2,
  parameter int DELAY_WIDTH    = DELAY_WIDTH_DEF,
  parameter int SETTLE_FRAMES  = 1,
  parameter int MEAS_FRAMES    = 2,
  parameter int ERR_THRESH     = 0,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input logic               clk_i,
  input logic               srst_i,
  csi2_deskew_cal_if.slave  bus
);

  localparam int LANE_W = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int FRM_W  = $clog2(SETTLE_FRAMES + MEAS_FRAMES + 1);
  localparam logic [DELAY_WIDTH-1:0] TAP_MAX   = {DELAY_WIDTH{1'b1}};
  localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(DATA_LANES - 1);

  cal_state_t               state, state_nxt;
  logic [LANE_W-1:0]        lane;
  logic [DELAY_WIDTH-1:0]   tap;
  logic [FRM_W-1:0]         frm_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [ERR_CNT_WIDTH:0]   err_sum;
  logic                     tmo_flag;
  logic                     settle_last, meas_last, tmo_hit;
  logic                     trk_clear, trk_step, trk_good;
  logic [DELAY_WIDTH-1:0]   best_start, centre_tap;
  logic [DELAY_WIDTH:0]     best_len;

  assign settle_last = bus.frame_start_i && (frm_cnt == FRM_W'(SETTLE_FRAMES - 1));
  assign meas_last   = bus.frame_start_i && (frm_cnt == FRM_W'(MEAS_FRAMES - 1));
  // A frame start in the same cycle always wins over the timeout.
  assign tmo_hit     = !bus.frame_start_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err_sum     = {1'b0, err_cnt} + {{ERR_CNT_WIDTH{1'b0}}, bus.header_err_i}
                                       + {{ERR_CNT_WIDTH{1'b0}}, bus.crc_err_i};
  assign centre_tap  = DELAY_WIDTH'({1'b0, best_start} + ((best_len - (DELAY_WIDTH+1)'(1)) >> 1));

  assign trk_clear = (state == LOAD) || (state == COMMIT);
  assign trk_step  = (state == EVAL);
  assign trk_good  = !tmo_flag && (err_cnt <= ERR_CNT_WIDTH'(ERR_THRESH));

  csi2_eye_tracker #(.DELAY_WIDTH(DELAY_WIDTH)) u_tracker (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .clear      (trk_clear),
    .step       (trk_step),
    .good       (trk_good),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = LOAD;
      LOAD:    state_nxt = APPLY;
      APPLY:   state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = MEASURE;
               else if (tmo_hit) state_nxt = EVAL;
      MEASURE: if (meas_last || tmo_hit) state_nxt = EVAL;
      EVAL:    state_nxt = (tap == TAP_MAX) ? COMMIT : APPLY;
      COMMIT:  state_nxt = (lane == LAST_LANE) ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      lane             <= '0;
      tap              <= '0;
      frm_cnt          <= '0;
      tmo_cnt          <= '0;
      err_cnt          <= '0;
      tmo_flag         <= 1'b0;
      bus.lane_delay_o <= '0;
      bus.delay_act_o  <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.lane_fail_o  <= '0;
      bus.eye_width_o  <= '0;
    end else begin
      bus.delay_act_o <= 1'b0;
      bus.done_o      <= (state_nxt == DONE);
      bus.busy_o      <= (state != IDLE) && (state != DONE) && (state_nxt != DONE);
      case (state)
        LOAD: begin
          bus.lane_delay_o <= bus.init_delay_i;
          bus.lane_fail_o  <= '0;
          bus.eye_width_o  <= '0;
          lane             <= '0;
          tap              <= '0;
        end
        APPLY: begin
          bus.lane_delay_o[lane] <= tap;
          bus.delay_act_o        <= 1'b1;
          frm_cnt                <= '0;
          tmo_cnt                <= '0;
          tmo_flag               <= 1'b0;
        end
        SETTLE: begin
          if (bus.frame_start_i) begin
            tmo_cnt <= '0;
            if (settle_last) begin
              frm_cnt <= '0;
              err_cnt <= '0;
            end else begin
              frm_cnt <= frm_cnt + FRM_W'(1);
            end
          end else if (tmo_hit) begin
            tmo_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        MEASURE: begin
          err_cnt <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
          if (bus.frame_start_i) begin
            tmo_cnt <= '0;
            frm_cnt <= frm_cnt + FRM_W'(1);
          end else if (tmo_hit) begin
            tmo_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        EVAL: begin
          if (tap != TAP_MAX) tap <= tap + DELAY_WIDTH'(1);
        end
        COMMIT: begin
          if (best_len == '0) begin
            bus.lane_delay_o[lane] <= bus.init_delay_i[lane];
            bus.lane_fail_o[lane]  <= 1'b1;
          end else begin
            bus.lane_delay_o[lane] <= centre_tap;
          end
          bus.eye_width_o[lane] <= best_len;
          bus.delay_act_o       <= 1'b1;
          if (lane != LAST_LANE) begin
            lane <= lane + LANE_W'(1);
            tap  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_deskew_cal.sv
// Randomised sweeps against a per-lane eye map; a scoreboard predicts each run's final taps and widths.
module tb_csi2_deskew_cal;

  localparam int NT = 32;
  localparam int ACTS_PER_LANE = NT + 1;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  csi2_deskew_cal_if #(.DATA_LANES(2), .DELAY_WIDTH(5)) bus ();

  csi2_deskew_cal #(
    .DATA_LANES(2), .DELAY_WIDTH(5), .SETTLE_FRAMES(1), .MEAS_FRAMES(2),
    .ERR_THRESH(0), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0][4:0] delay;
    logic [1:0]      fail;
    logic [1:0][5:0] eye;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_poke_at = -1;
  int   stop_at = -1;
  bit   settle_err = 1'b0;
  bit   no_frames = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Longest all-good run found by scanning every start point; first longest wins.
  function automatic exp_t predict(input logic [31:0] m0, input logic [31:0] m1,
                                   input logic [1:0][4:0] init);
    exp_t r;
    logic [31:0] m;
    int best, bs, len;
    for (int l = 0; l < 2; l++) begin
      m = (l == 0) ? m0 : m1;
      best = 0;
      bs = 0;
      for (int s = 0; s < NT; s++) begin
        len = 0;
        while (s + len < NT && m[s + len]) len++;
        if (len > best) begin
          best = len;
          bs = s;
        end
      end
      r.eye[l]   = 6'(best);
      r.fail[l]  = (best == 0);
      r.delay[l] = (best == 0) ? init[l] : 5'(bs + (best - 1) / 2);
    end
    return r;
  endfunction

  task automatic step(input logic fs, input logic he, input logic ce);
    bus.frame_start_i = fs;
    bus.header_err_i  = he;
    bus.crc_err_i     = ce;
    @(posedge clk);
    #1;
    bus.frame_start_i = 1'b0;
    bus.header_err_i  = 1'b0;
    bus.crc_err_i     = 1'b0;
    bus.start_i       = 1'b0;
    cyc++;
  endtask

  // One tap: a settle frame (optionally noisy), then two measured frames with one error burst if bad.
  task automatic run_tap(input bit bad);
    int g, pos, k, bad_frame;
    g = $urandom_range(1, 4);
    for (int i = 0; i < g; i++)
      step(1'b0, settle_err && ($urandom_range(0, 1) == 1), settle_err && ($urandom_range(0, 2) == 0));
    step(1'b1, 1'b0, 1'b0);
    bad_frame = $urandom_range(0, 1);
    for (int f = 0; f < 2; f++) begin
      g = $urandom_range(3, 8);
      pos = (bad && f == bad_frame) ? $urandom_range(0, g) : -1;
      k = $urandom_range(0, 2);
      for (int i = 0; i < g; i++)
        step(1'b0, (i == pos) && (k != 1), (i == pos) && (k != 0));
      step(1'b1, (g == pos) && (k != 1), (g == pos) && (k != 0));
    end
  endtask

  task automatic sweep(input logic [31:0] m0, input logic [31:0] m1,
                       input logic [1:0][4:0] init, input int budget);
    int acts, t0, idx, lane;
    bit fin;
    logic [9:0] first_val;
    acts = 0;
    fin = 1'b0;
    first_val = {init[1], 5'd0};
    if (stop_at < 0) exp_q.push_back(predict(m0, m1, init));
    bus.init_delay_i = init;
    bus.start_i = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    t0 = cyc;
    while (!fin) begin
      if (cyc == t0 + 1) check("busy_after_start", 16'(bus.busy_o), 16'd1);
      if (bus.done_o === 1'b1) begin
        fin = 1'b1;
      end else if (cyc - t0 > budget) begin
        vectors++;
        miscompares++;
        $display("FAIL sweep_timeout: no done_o after %0d cycles, required within %0d", cyc - t0, budget);
        fin = 1'b1;
      end else if (bus.delay_act_o === 1'b1) begin
        idx = acts % ACTS_PER_LANE;
        lane = acts / ACTS_PER_LANE;
        if (acts == 0) begin
          check("first_act_cycle", 16'(cyc - t0), 16'd2);
          check("first_act_delay", 16'(bus.lane_delay_o), 16'(first_val));
        end
        acts++;
        if (acts - 1 == stop_at) begin
          fin = 1'b1;
        end else begin
          if (acts - 1 == start_poke_at) bus.start_i = 1'b1;
          if (idx < NT && !no_frames) run_tap(!((lane == 0) ? m0[idx] : m1[idx]));
          else step(1'b0, 1'b0, 1'b0);
        end
      end else begin
        step(1'b0, 1'b0, 1'b0);
      end
    end
    if (stop_at < 0) begin
      step(1'b0, 1'b0, 1'b0);
      check("done_one_cycle", 16'(bus.done_o), 16'd0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lane_delay"}, 16'(bus.lane_delay_o), 16'd0);
    check({tag, "_delay_act"},  16'(bus.delay_act_o),  16'd0);
    check({tag, "_busy"},       16'(bus.busy_o),       16'd0);
    check({tag, "_done"},       16'(bus.done_o),       16'd0);
    check({tag, "_lane_fail"},  16'(bus.lane_fail_o),  16'd0);
    check({tag, "_eye_width"},  16'(bus.eye_width_o),  16'd0);
  endtask

  // Scoreboard monitor: compares final results whenever the DUT flags completion.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        check("busy_at_done", 16'(bus.busy_o), 16'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done_o=1, required no completion");
        end else begin
          e = exp_q.pop_front();
          check("lane_delay", 16'(bus.lane_delay_o), 16'(e.delay));
          check("lane_fail",  16'(bus.lane_fail_o),  16'(e.fail));
          check("eye_width",  16'(bus.eye_width_o),  16'(e.eye));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] ra, rb;
    srst = 1'b1;
    bus.start_i = 1'b0;
    bus.init_delay_i = '0;
    bus.frame_start_i = 1'b0;
    bus.header_err_i = 1'b0;
    bus.crc_err_i = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_all_zero("reset");
    srst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Lane 0 good 10..20, lane 1 good 5..9 and 22..30.
    sweep(32'h001F_FC00, 32'h7FC0_03E0, {5'd7, 5'd3}, 3000);
    // Lane 1 never good: falls back to its base tap.
    sweep(32'h001F_FC00, 32'h0000_0000, {5'd7, 5'd3}, 3000);
    // Two equal runs on lane 0: the lower one wins.
    sweep(32'h00F0_003C, 32'hFFFF_FFFF, {5'd1, 5'd2}, 3000);
    // No frames at all: every tap times out.
    no_frames = 1'b1;
    sweep(32'h0, 32'h0, {5'd9, 5'd21}, 2 * 32 * 66 + 200);
    no_frames = 1'b0;
    // Errors only while settling must not disqualify any tap.
    settle_err = 1'b1;
    sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, {5'd4, 5'd4}, 3000);
    settle_err = 1'b0;
    // Random eyes, with a start request landing mid-sweep.
    start_poke_at = 40;
    for (int n = 0; n < 2; n++) begin
      ra = $urandom() | $urandom();
      rb = $urandom() | $urandom();
      sweep(ra, rb, {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))}, 3000);
    end
    start_poke_at = -1;
    // Reset while lane 0 sits at tap 12.
    stop_at = 12;
    sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, {5'd11, 5'd13}, 3000);
    stop_at = -1;
    srst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_all_zero("srst");
    srst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    ra = $urandom() | $urandom();
    sweep(ra, 32'h0FF0_0FF0, {5'd17, 5'd30}, 3000);

    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("pending_expectations", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
